// File: rtl/bcd2bin_iter.sv
// Iterative BCD-to-binary converter using reverse double-dabble: one right
// shift per SHIFT cycle, with a per-digit "subtract 3 if >= 8" in between.
module bcd2bin_iter #(
  parameter int DIGITS = 5,
  parameter int BIN_W  = 17
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ADJ,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WORK_W-1:0]   work_q,  work_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [BIN_W-1:0]    bin_q,   bin_d;
  logic                err_q,   err_d;
  logic                bad_digit;

  // Any operand nibble outside 0..9 flags the whole operand as invalid.
  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every variable gets its default first so no path can infer a latch.
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        // abort outranks start, so a simultaneous request is dropped.
        if (start && !abort) begin
          work_d  = {bcd_in, {BIN_W{1'b0}}};
          cnt_d   = CNT_W'(BIN_W);
          err_d   = bad_digit;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          work_d = work_q >> 1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            // Capture on the way into DONE so bin_out is valid with the pulse.
            bin_d   = work_d[BIN_W-1:0];
            state_d = DONE;
          end else begin
            state_d = ADJ;
          end
        end
      end

      ADJ: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          for (int d = 0; d < DIGITS; d++) begin
            if (work_q[BIN_W + 4*d +: 4] >= 4'd8)
              work_d[BIN_W + 4*d +: 4] = work_q[BIN_W + 4*d +: 4] - 4'd3;
          end
          state_d = SHIFT;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the working register is reset too, since it must read zero after reset.
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule
